// File: rtl/gpio_pkg.sv
// Shared constants for the 8-bit digital I/O port controller: register
// offsets within the 32-byte port window, interrupt vector codes and
// small helpers for the priority logic.
package gpio_pkg;

    localparam int PIN_COUNT = 8;

    // Register offsets (MAB[4:0] with bit 0 forced to 0)
    localparam logic [4:0] OFS_IN   = 5'h00;
    localparam logic [4:0] OFS_OUT  = 5'h02;
    localparam logic [4:0] OFS_DIR  = 5'h04;
    localparam logic [4:0] OFS_REN  = 5'h06;
    localparam logic [4:0] OFS_SEL0 = 5'h0A;
    localparam logic [4:0] OFS_SEL1 = 5'h0C;
    localparam logic [4:0] OFS_IV   = 5'h0E;
    localparam logic [4:0] OFS_SELC = 5'h16;
    localparam logic [4:0] OFS_IES  = 5'h18;
    localparam logic [4:0] OFS_IE   = 5'h1A;
    localparam logic [4:0] OFS_IFG  = 5'h1C;

    // Interrupt vector codes, pin 0 has the highest priority
    localparam logic [7:0] IV_NONE = 8'h00;
    localparam logic [7:0] IV_P0   = 8'h02;
    localparam logic [7:0] IV_P1   = 8'h04;
    localparam logic [7:0] IV_P2   = 8'h06;
    localparam logic [7:0] IV_P3   = 8'h08;
    localparam logic [7:0] IV_P4   = 8'h0A;
    localparam logic [7:0] IV_P5   = 8'h0C;
    localparam logic [7:0] IV_P6   = 8'h0E;
    localparam logic [7:0] IV_P7   = 8'h10;

    localparam logic [7:0] IV_CODE [PIN_COUNT] =
        '{IV_P0, IV_P1, IV_P2, IV_P3, IV_P4, IV_P5, IV_P6, IV_P7};

    // Vector code of the lowest pending pin, IV_NONE when nothing pends
    function automatic logic [7:0] iv_encode(input logic [7:0] pend);
        iv_encode = IV_NONE;
        for (int n = PIN_COUNT - 1; n >= 0; n--) begin
            if (pend[n]) iv_encode = IV_CODE[n];
        end
    endfunction

    // One-hot mask of the lowest set bit (zero when no bit is set)
    function automatic logic [7:0] lowest_bit(input logic [7:0] v);
        lowest_bit = v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/gpio_port_ctrl_if.sv
// Peripheral bus seen by one I/O port. The master drives address, write
// data and the one-cycle MW/MR strobes; the port returns combinational
// read data on MDB_out.
interface gpio_port_ctrl_if;

    logic [15:0] MAB;
    logic [15:0] MDB_in;
    logic [15:0] MDB_out;
    logic        MW;
    logic        MR;

    modport master (output MAB, output MDB_in, output MW, output MR, input MDB_out);
    modport slave  (input MAB, input MDB_in, input MW, input MR, output MDB_out);

endinterface

// File: rtl/gpio_sync_edge.sv
// One pin input path: multi-flop synchroniser, a previous-value flop and
// the edge event selected by the pin's edge-select bit. Events are gated
// by arm so pads that are already high at reset release do not flag.
module gpio_sync_edge
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pad,
    input  logic ies,
    input  logic arm,
    output logic sync_q,
    output logic ev
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;
    logic                   rise;
    logic                   fall;

    // Shift the raw pad through the synchroniser and remember the last synced value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pad};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_q = chain[SYNC_STAGES-1];
    assign rise   = sync_q & ~prev;
    assign fall   = ~sync_q & prev;
    assign ev     = arm & (ies ? fall : rise);

endmodule

// File: rtl/gpio_port_ctrl.sv
// Register file and interrupt controller for one 8-bit I/O port. Holds the
// OUT/DIR/REN/SEL0/SEL1/IES/IE/IFG registers, drives the pin-mux controls,
// turns synchronised pad edges into IFG bits and produces IRQ and the
// IV priority vector with read-to-clear.
module gpio_port_ctrl
    import gpio_pkg::*;
#(
    parameter int          PORT_WIDTH  = PIN_COUNT,
    parameter logic [15:0] BASE_ADDR   = 16'h0200,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                MCLK,
    input  logic                reset,
    gpio_port_ctrl_if.slave     bus,
    input  logic [7:0]          PxIN_pad,
    output logic [7:0]          PxOUT,
    output logic [7:0]          PxDIR,
    output logic [7:0]          PxREN,
    output logic [15:0]         PxSEL,
    output logic                IRQ
);

    // Bus handshake: no ready/valid back-pressure. A cycle with MW=1 and a
    // selected address commits the write on that MCLK edge; a cycle with MR=1
    // returns data combinationally in the same cycle and, for IV, performs the
    // clear on that edge. MW and MR may both be high in one cycle.

    localparam int          CW       = $clog2(SYNC_STAGES + 2);
    localparam logic [CW-1:0] ARM_LOAD = CW'(SYNC_STAGES + 1);

    logic [7:0]    sel0, sel1, ies, ie, ifg, ifg_nxt;
    logic [7:0]    sync_in, ev;
    logic [7:0]    pend, iv, clr_mask, wdata, rdata;
    logic [CW-1:0] arm_cnt;
    logic          arm;
    logic          selected, wr, rd;
    logic [4:0]    ofs;
    logic          unused_bits;

    assign selected    = (bus.MAB[15:5] == BASE_ADDR[15:5]);
    assign ofs         = {bus.MAB[4:1], 1'b0};
    assign wr          = selected & bus.MW;
    assign rd          = selected & bus.MR;
    assign wdata       = bus.MDB_in[7:0];
    assign unused_bits = ^{bus.MDB_in[15:8], bus.MAB[0]};

    assign pend     = ifg & ie;
    assign iv       = iv_encode(pend);
    assign IRQ      = |pend;
    assign clr_mask = (rd && (ofs == OFS_IV)) ? lowest_bit(pend) : 8'h00;
    assign arm      = (arm_cnt == '0);

    // Count down after reset so the synchroniser fills before edges are trusted
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset)               arm_cnt <= ARM_LOAD;
        else if (arm_cnt != '0)  arm_cnt <= arm_cnt - 1'b1;
    end

    // Per-pin input path and pin-mux function select interleave
    for (genvar n = 0; n < PORT_WIDTH; n++) begin : g_pin
        gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
            .clk    (MCLK),
            .rst    (reset),
            .pad    (PxIN_pad[n]),
            .ies    (ies[n]),
            .arm    (arm),
            .sync_q (sync_in[n]),
            .ev     (ev[n])
        );
        assign PxSEL[2*n+1:2*n] = {sel1[n], sel0[n]};
    end

    // IFG next value: software write, then IV-read clear, then edge set wins
    always_comb begin
        ifg_nxt = ifg;
        if (wr && (ofs == OFS_IFG)) ifg_nxt = wdata;
        ifg_nxt = (ifg_nxt & ~clr_mask) | ev;
    end

    // Register file writes
    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            PxOUT <= 8'h00;
            PxDIR <= 8'h00;
            PxREN <= 8'h00;
            sel0  <= 8'h00;
            sel1  <= 8'h00;
            ies   <= 8'h00;
            ie    <= 8'h00;
            ifg   <= 8'h00;
        end else begin
            ifg <= ifg_nxt;
            if (wr) begin
                case (ofs)
                    OFS_OUT:  PxOUT <= wdata;
                    OFS_DIR:  PxDIR <= wdata;
                    OFS_REN:  PxREN <= wdata;
                    OFS_SEL0: sel0  <= wdata;
                    OFS_SEL1: sel1  <= wdata;
                    OFS_SELC: begin
                        sel0 <= sel0 ^ wdata;
                        sel1 <= sel1 ^ wdata;
                    end
                    OFS_IES:  ies   <= wdata;
                    OFS_IE:   ie    <= wdata;
                    default:  ;
                endcase
            end
        end
    end

    // Read data mux, zero when the port is not being read
    always_comb begin
        rdata = 8'h00;
        case (ofs)
            OFS_IN:   rdata = sync_in;
            OFS_OUT:  rdata = PxOUT;
            OFS_DIR:  rdata = PxDIR;
            OFS_REN:  rdata = PxREN;
            OFS_SEL0: rdata = sel0;
            OFS_SEL1: rdata = sel1;
            OFS_IV:   rdata = iv;
            OFS_IES:  rdata = ies;
            OFS_IE:   rdata = ie;
            OFS_IFG:  rdata = ifg;
            default:  rdata = 8'h00;
        endcase
        bus.MDB_out = rd ? {8'h00, rdata} : 16'h0000;
    end

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// Bench for gpio_port_ctrl: a register-map vector table, hand-timed edge,
// IV and reset sequences, then randomized bus/pad traffic against a
// cycle-level reference model built from the port's documented rules.
module tb_gpio_port_ctrl;
    import gpio_pkg::*;

    localparam logic [15:0] BASE = 16'h0200;

    // ---------------- clock / reset ----------------
    logic        MCLK = 1'b0;
    logic        reset;
    logic [7:0]  PxIN_pad;
    logic [7:0]  PxOUT, PxDIR, PxREN;
    logic [15:0] PxSEL;
    logic        IRQ;

    always #5 MCLK = ~MCLK;

    gpio_port_ctrl_if bus ();

    gpio_port_ctrl #(
        .PORT_WIDTH  (8),
        .BASE_ADDR   (BASE),
        .SYNC_STAGES (2)
    ) dut (
        .MCLK     (MCLK),
        .reset    (reset),
        .bus      (bus),
        .PxIN_pad (PxIN_pad),
        .PxOUT    (PxOUT),
        .PxDIR    (PxDIR),
        .PxREN    (PxREN),
        .PxSEL    (PxSEL),
        .IRQ      (IRQ)
    );

    // ---------------- scoreboard ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [15:0] act);
        logic [15:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got %h with no expected value queued", name, act);
        end else begin
            exp = exp_q.pop_front();
            check(name, act, exp);
        end
    endtask

    function automatic logic [15:0] a(input logic [4:0] o);
        return BASE | {11'h000, o};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        @(negedge MCLK);
        bus.MAB    = addr;
        bus.MDB_in = data;
        bus.MW     = 1'b1;
        @(negedge MCLK);
        bus.MW     = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [15:0] data);
        @(negedge MCLK);
        bus.MAB = addr;
        bus.MR  = 1'b1;
        #1;
        data = bus.MDB_out;
        @(negedge MCLK);
        bus.MR  = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [15:0] addr, input logic [15:0] exp);
        logic [15:0] rd;
        exp_q.push_back(exp);
        bus_read(addr, rd);
        sb_check(name, rd);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl [NVEC];

    // ---------------- reference model state ----------------
    logic [7:0] m_out, m_dir, m_ren, m_sel0, m_sel1, m_ies, m_ie, m_ifg;
    logic [7:0] m_p1, m_p2, m_p3;   // pad values applied 1, 2, 3 cycles ago

    function automatic logic [7:0] m_iv(input logic [7:0] pend);
        logic [7:0] v;
        v = 8'h00;
        for (int n = 7; n >= 0; n--) if (pend[n]) v = 8'(2 * (n + 1));
        return v;
    endfunction

    function automatic logic [7:0] m_read(input logic [4:0] o, input logic [7:0] ivv);
        case (o)
            5'h00:   return m_p2;
            5'h02:   return m_out;
            5'h04:   return m_dir;
            5'h06:   return m_ren;
            5'h0A:   return m_sel0;
            5'h0C:   return m_sel1;
            5'h0E:   return ivv;
            5'h18:   return m_ies;
            5'h1A:   return m_ie;
            5'h1C:   return m_ifg;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [15:0] m_psel();
        logic [15:0] s;
        s = 16'h0000;
        for (int n = 0; n < 8; n++) s = s | (16'({m_sel1[n], m_sel0[n]}) << (2 * n));
        return s;
    endfunction

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        logic [15:0] addr;
        logic [7:0]  pend, ivv, ev, nifg, d;
        logic [4:0]  o;
        logic        sel;
        logic [15:0] exp_rd;
        int          idx;

        bus.MAB    = 16'h0000;
        bus.MDB_in = 16'h0000;
        bus.MW     = 1'b0;
        bus.MR     = 1'b0;
        PxIN_pad   = 8'hFF;
        reset      = 1'b1;

        tbl[0]  = '{1'b1, a(OFS_OUT),  16'h00A5, 16'h0000};
        tbl[1]  = '{1'b1, a(OFS_DIR),  16'h000F, 16'h0000};
        tbl[2]  = '{1'b1, a(OFS_SEL0), 16'h0033, 16'h0000};
        tbl[3]  = '{1'b1, a(OFS_SELC), 16'h00FF, 16'h0000};
        tbl[4]  = '{1'b0, a(OFS_OUT),  16'h0000, 16'h00A5};
        tbl[5]  = '{1'b0, a(OFS_DIR),  16'h0000, 16'h000F};
        tbl[6]  = '{1'b0, a(OFS_SEL0), 16'h0000, 16'h00CC};
        tbl[7]  = '{1'b0, a(OFS_SEL1), 16'h0000, 16'h00FF};
        tbl[8]  = '{1'b0, a(OFS_SELC), 16'h0000, 16'h0000};
        tbl[9]  = '{1'b1, a(OFS_REN),  16'hAB12, 16'h0000};
        tbl[10] = '{1'b0, a(OFS_REN),  16'h0000, 16'h0012};
        tbl[11] = '{1'b0, a(5'h03),    16'h0000, 16'h00A5};
        tbl[12] = '{1'b0, a(5'h08),    16'h0000, 16'h0000};
        tbl[13] = '{1'b1, a(5'h10),    16'h0077, 16'h0000};
        tbl[14] = '{1'b0, a(5'h10),    16'h0000, 16'h0000};
        tbl[15] = '{1'b0, 16'h0222,    16'h0000, 16'h0000};
        tbl[16] = '{1'b1, 16'h0222,    16'h0000, 16'h0000};
        tbl[17] = '{1'b0, a(OFS_OUT),  16'h0000, 16'h00A5};
        tbl[18] = '{1'b1, a(OFS_IN),   16'h0055, 16'h0000};
        tbl[19] = '{1'b0, a(OFS_IN),   16'h0000, 16'h00FF};

        // Reset with pads high: nothing may flag after release
        repeat (3) @(negedge MCLK);
        #1;
        check("rst_out", {8'h00, PxOUT}, 16'h0000);
        check("rst_dir", {8'h00, PxDIR}, 16'h0000);
        check("rst_sel", PxSEL, 16'h0000);
        check("rst_irq", {15'h0, IRQ}, 16'h0000);
        @(negedge MCLK);
        reset = 1'b0;
        repeat (10) @(negedge MCLK);
        read_expect("arm_ifg", a(OFS_IFG), 16'h0000);
        read_expect("arm_in", a(OFS_IN), 16'h00FF);
        check("arm_irq", {15'h0, IRQ}, 16'h0000);

        // Register map vectors
        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].is_wr) begin
                bus_write(tbl[i].addr, tbl[i].data);
            end else begin
                read_expect($sformatf("tbl[%0d]", i), tbl[i].addr, tbl[i].exp);
            end
        end
        #1;
        check("pxout", {8'h00, PxOUT}, 16'h00A5);
        check("pxdir", {8'h00, PxDIR}, 16'h000F);
        check("pxren", {8'h00, PxREN}, 16'h0012);
        check("pxsel", PxSEL, 16'hFAFA);

        // Rising edge on pin 0: IFG sets two edges after the pad settles
        PxIN_pad = 8'h00;
        repeat (5) @(negedge MCLK);
        bus_write(a(OFS_IE), 16'h0081);
        bus_write(a(OFS_IES), 16'h0000);
        bus_write(a(OFS_IFG), 16'h0000);
        @(negedge MCLK);
        PxIN_pad = 8'h01;
        @(negedge MCLK); #1;
        check("edge_k", {15'h0, IRQ}, 16'h0000);
        @(negedge MCLK); #1;
        check("edge_k1", {15'h0, IRQ}, 16'h0000);
        @(negedge MCLK); #1;
        check("edge_k2", {15'h0, IRQ}, 16'h0001);
        read_expect("edge_ifg", a(OFS_IFG), 16'h0001);
        bus_write(a(OFS_IFG), 16'h0000);
        PxIN_pad = 8'h00;
        repeat (5) @(negedge MCLK);
        read_expect("fall_ifg", a(OFS_IFG), 16'h0000);

        // IV priority and read-to-clear
        bus_write(a(OFS_IFG), 16'h0081);
        read_expect("iv_1", a(OFS_IV), 16'h0002);
        read_expect("iv_ifg1", a(OFS_IFG), 16'h0080);
        #1;
        check("iv_irq1", {15'h0, IRQ}, 16'h0001);
        read_expect("iv_2", a(OFS_IV), 16'h0010);
        read_expect("iv_ifg2", a(OFS_IFG), 16'h0000);
        #1;
        check("iv_irq2", {15'h0, IRQ}, 16'h0000);
        read_expect("iv_3", a(OFS_IV), 16'h0000);

        // Edge on pin 3 lands on the same edge as a software IFG clear
        @(negedge MCLK);
        PxIN_pad = 8'h08;
        @(negedge MCLK);
        @(negedge MCLK);
        bus.MAB    = a(OFS_IFG);
        bus.MDB_in = 16'h0000;
        bus.MW     = 1'b1;
        @(negedge MCLK);
        bus.MW     = 1'b0;
        read_expect("coll_ifg", a(OFS_IFG), 16'h0008);

        // Reset in the middle of activity
        bus_write(a(OFS_IFG), 16'h00FF);
        bus_write(a(OFS_OUT), 16'h0055);
        bus_write(a(OFS_IE), 16'h00FF);
        PxIN_pad = 8'hFF;
        #1;
        check("pre_rst_irq", {15'h0, IRQ}, 16'h0001);
        @(negedge MCLK);
        #2;
        reset   = 1'b1;
        bus.MAB = a(OFS_IFG);
        bus.MR  = 1'b1;
        #1;
        check("mid_rst_out", {8'h00, PxOUT}, 16'h0000);
        check("mid_rst_irq", {15'h0, IRQ}, 16'h0000);
        check("mid_rst_sel", PxSEL, 16'h0000);
        check("mid_rst_rd", bus.MDB_out, 16'h0000);
        bus.MR = 1'b0;
        repeat (2) @(negedge MCLK);
        reset = 1'b0;
        repeat (8) @(negedge MCLK);
        read_expect("rearm_ifg", a(OFS_IFG), 16'h0000);
        read_expect("rearm_in", a(OFS_IN), 16'h00FF);

        // Randomized traffic against the reference model
        m_out = 8'h00; m_dir = 8'h00; m_ren = 8'h00; m_sel0 = 8'h00;
        m_sel1 = 8'h00; m_ies = 8'h00; m_ie = 8'h00; m_ifg = 8'h00;
        m_p1 = 8'hFF; m_p2 = 8'hFF; m_p3 = 8'hFF;
        for (int it = 0; it < 600; it++) begin
            @(negedge MCLK);
            if ($urandom_range(0, 3) == 0) PxIN_pad = 8'($urandom);
            if ($urandom_range(0, 4) == 0) addr = 16'($urandom);
            else                           addr = BASE | 16'($urandom_range(0, 31));
            bus.MAB    = addr;
            bus.MDB_in = 16'($urandom);
            bus.MW     = ($urandom_range(0, 3) == 0);
            bus.MR     = ($urandom_range(0, 1) == 0);
            #1;

            sel    = (addr[15:5] == BASE[15:5]);
            o      = {addr[4:1], 1'b0};
            pend   = m_ifg & m_ie;
            ivv    = m_iv(pend);
            exp_rd = (sel && bus.MR) ? {8'h00, m_read(o, ivv)} : 16'h0000;
            exp_q.push_back(exp_rd);
            sb_check("rnd_rd", bus.MDB_out);
            check("rnd_irq", {15'h0, IRQ}, {15'h0, |pend});
            check("rnd_out", {PxDIR, PxOUT}, {m_dir, m_out});
            check("rnd_sel", PxSEL, m_psel());

            // Advance the model across the coming edge
            ev   = ((m_p2 & ~m_p3) & ~m_ies) | ((~m_p2 & m_p3) & m_ies);
            nifg = m_ifg;
            d    = bus.MDB_in[7:0];
            if (sel && bus.MW) begin
                case (o)
                    5'h02: m_out = d;
                    5'h04: m_dir = d;
                    5'h06: m_ren = d;
                    5'h0A: m_sel0 = d;
                    5'h0C: m_sel1 = d;
                    5'h16: begin m_sel0 = m_sel0 ^ d; m_sel1 = m_sel1 ^ d; end
                    5'h18: m_ies = d;
                    5'h1A: m_ie = d;
                    5'h1C: nifg = d;
                    default: ;
                endcase
            end
            if (sel && bus.MR && (o == 5'h0E) && (ivv != 8'h00)) begin
                idx = int'(ivv) / 2 - 1;
                nifg[idx] = 1'b0;
            end
            m_ifg = nifg | ev;
            m_p3  = m_p2;
            m_p2  = m_p1;
            m_p1  = PxIN_pad;
        end
        @(negedge MCLK);
        bus.MW = 1'b0;
        bus.MR = 1'b0;
        #1;
        check("end_ren", {8'h00, PxREN}, {8'h00, m_ren});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
